// File: rtl/scan_sequencer_if.sv
// Handshake bundle between a scan controller and the scan sequencer.
// The sequencer side (slave) consumes RUN/DIV/GAP/MASK and drives the decoder selects and pulses.
interface scan_sequencer_if #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned GAP_WIDTH = 4
);
    logic                 RUN;
    logic [DIV_WIDTH-1:0] DIV;
    logic [GAP_WIDTH-1:0] GAP;
    logic [3:0]           MASK;
    logic                 EN;
    logic                 I0;
    logic                 I1;
    logic                 STEP;
    logic                 FRAME;

    modport master (
        output RUN, DIV, GAP, MASK,
        input  EN, I0, I1, STEP, FRAME
    );

    modport slave (
        input  RUN, DIV, GAP, MASK,
        output EN, I0, I1, STEP, FRAME
    );
endinterface

// File: rtl/scan_sequencer.sv
// Registered scan sequencer feeding a 2-to-4 decoder: walks enabled outputs in ascending order,
// holding each for a latched dwell, optionally blanking between dwells, and flagging steps/frame wraps.
module scan_sequencer #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned GAP_WIDTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    scan_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           idx, idx_nxt;
    logic [DIV_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt;
    logic [GAP_WIDTH-1:0] gap_cnt, gap_cnt_nxt;
    logic [GAP_WIDTH-1:0] gap_lat, gap_lat_nxt;
    logic                 en, en_nxt;
    logic                 step, step_nxt;
    logic                 frame, frame_nxt;

    logic [1:0]           low_idx_c;
    logic [1:0]           above_idx_c;
    logic                 above_found_c;
    logic                 advance_c;
    logic                 load_c;

    // Lowest enabled output, and the lowest enabled output strictly above the current index.
    always_comb begin
        low_idx_c     = 2'd0;
        above_idx_c   = 2'd0;
        above_found_c = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.MASK[k]) begin
                low_idx_c = 2'(k);
                if (2'(k) > idx) begin
                    above_idx_c   = 2'(k);
                    above_found_c = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic; the dwell counter holds remaining cycles minus one.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        dwell_cnt_nxt = dwell_cnt;
        gap_cnt_nxt   = gap_cnt;
        gap_lat_nxt   = gap_lat;
        en_nxt        = 1'b0;
        step_nxt      = 1'b0;
        frame_nxt     = 1'b0;
        advance_c     = 1'b0;
        load_c        = 1'b0;

        case (state)
            IDLE: begin
                idx_nxt = 2'd0;
                if (bus.MASK != 4'd0) begin
                    state_nxt = DWELL;
                    idx_nxt   = low_idx_c;
                    load_c    = 1'b1;
                end
            end
            DWELL: begin
                if (dwell_cnt == '0) begin
                    if (gap_lat != '0) begin
                        state_nxt   = BLANK;
                        gap_cnt_nxt = gap_lat - GAP_WIDTH'(1);
                    end else begin
                        advance_c = 1'b1;
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt - DIV_WIDTH'(1);
                    en_nxt        = 1'b1;
                end
            end
            BLANK: begin
                if (gap_cnt == '0) begin
                    advance_c = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
            end
        endcase

        // A wrap (no enabled output above the current one) is exactly the new<=old case.
        if (advance_c) begin
            if (bus.MASK == 4'd0) begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
            end else begin
                state_nxt = DWELL;
                idx_nxt   = above_found_c ? above_idx_c : low_idx_c;
                frame_nxt = ~above_found_c;
                load_c    = 1'b1;
            end
        end

        if (load_c) begin
            dwell_cnt_nxt = (bus.DIV == '0) ? '0 : bus.DIV - DIV_WIDTH'(1);
            gap_lat_nxt   = bus.GAP;
            en_nxt        = 1'b1;
            step_nxt      = 1'b1;
        end

        if (!bus.RUN) begin
            state_nxt     = IDLE;
            idx_nxt       = 2'd0;
            dwell_cnt_nxt = '0;
            gap_cnt_nxt   = '0;
            en_nxt        = 1'b0;
            step_nxt      = 1'b0;
            frame_nxt     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= 2'd0;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            gap_lat   <= '0;
            en        <= 1'b0;
            step      <= 1'b0;
            frame     <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            gap_lat   <= gap_lat_nxt;
            en        <= en_nxt;
            step      <= step_nxt;
            frame     <= frame_nxt;
        end
    end

    assign bus.EN    = en;
    assign bus.I0    = idx[0];
    assign bus.I1    = idx[1];
    assign bus.STEP  = step;
    assign bus.FRAME = frame;
endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed vector table, hand sequences and
// randomized steady-state segments checked against an arithmetic waveform model.
module tb_scan_sequencer;
    localparam int unsigned DW = 16;
    localparam int unsigned GW = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    scan_sequencer_if #(.DIV_WIDTH(DW), .GAP_WIDTH(GW)) bus ();

    scan_sequencer #(.DIV_WIDTH(DW), .GAP_WIDTH(GW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rst;
        logic          run;
        logic [DW-1:0] div;
        logic [GW-1:0] gap;
        logic [3:0]    mask;
        logic [4:0]    exp;   // {EN, I1, I0, STEP, FRAME}
    } vec_t;

    vec_t vecs[25];

    function automatic logic [4:0] observed();
        return {bus.EN, bus.I1, bus.I0, bus.STEP, bus.FRAME};
    endfunction

    // Expected outputs t cycles after the run starts from idle, inputs held steady.
    function automatic logic [4:0] model(int t, logic [3:0] mask, int d, int g);
        int lst[4];
        int n;
        int deff;
        int p;
        int pos;
        int slot;
        int off;
        logic [1:0] ix;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            lst[k] = 0;
            if (mask[k]) begin
                lst[n] = k;
                n++;
            end
        end
        if (n == 0) return 5'b00000;
        deff = (d == 0) ? 1 : d;
        p    = deff + g;
        pos  = t % (n * p);
        slot = pos / p;
        off  = pos % p;
        ix   = 2'(lst[slot]);
        return {off < deff, ix, off == 0, (off == 0) && (slot == 0) && (t >= p)};
    endfunction

    task automatic chk(string name, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {EN,I1,I0,STEP,FRAME}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Park in idle for one cycle, then run with steady inputs and compare n cycles to the model.
    task automatic run_segment(string name, logic [3:0] mask, int d, int g, int n);
        bus.RUN  = 1'b0;
        bus.MASK = mask;
        bus.DIV  = DW'(d);
        bus.GAP  = GW'(g);
        tick();
        chk({name, "_idle"}, observed(), 5'b00000);
        bus.RUN = 1'b1;
        for (int t = 0; t < n; t++) begin
            tick();
            chk($sformatf("%s_t%0d", name, t), observed(), model(t, mask, d, g));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 16'd3, 4'd1, 4'b1111, 5'b00000};
        vecs[1]  = '{1'b1, 1'b1, 16'd3, 4'd1, 4'b1111, 5'b00000};
        vecs[2]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b10010};
        vecs[3]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b00000};
        vecs[4]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b00000};
        vecs[5]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b10011};
        vecs[6]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b00000};
        vecs[7]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b00000};
        vecs[8]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b10011};
        vecs[9]  = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b0001, 5'b00000};
        vecs[10] = '{1'b0, 1'b0, 16'd0, 4'd2, 4'b0001, 5'b00000};
        vecs[11] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b11010};
        vecs[12] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b01000};
        vecs[13] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b01000};
        vecs[14] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b11110};
        vecs[15] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b01100};
        vecs[16] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b01100};
        vecs[17] = '{1'b0, 1'b1, 16'd0, 4'd2, 4'b1100, 5'b11011};
        vecs[18] = '{1'b0, 1'b0, 16'd1, 4'd0, 4'b0100, 5'b00000};
        vecs[19] = '{1'b0, 1'b1, 16'd1, 4'd0, 4'b0100, 5'b11010};
        vecs[20] = '{1'b0, 1'b1, 16'd1, 4'd0, 4'b0100, 5'b11011};
        vecs[21] = '{1'b0, 1'b1, 16'd1, 4'd0, 4'b0100, 5'b11011};
        vecs[22] = '{1'b0, 1'b0, 16'd1, 4'd0, 4'b0000, 5'b00000};
        vecs[23] = '{1'b0, 1'b1, 16'd1, 4'd0, 4'b0000, 5'b00000};
        vecs[24] = '{1'b0, 1'b1, 16'd1, 4'd0, 4'b0000, 5'b00000};

        rst      = 1'b1;
        bus.RUN  = 1'b1;
        bus.DIV  = DW'(3);
        bus.GAP  = GW'(1);
        bus.MASK = 4'b1111;

        for (int i = 0; i < 25; i++) begin
            rst      = vecs[i].rst;
            bus.RUN  = vecs[i].run;
            bus.DIV  = vecs[i].div;
            bus.GAP  = vecs[i].gap;
            bus.MASK = vecs[i].mask;
            tick();
            chk($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        run_segment("full_mask", 4'b1111, 3, 1, 34);
        run_segment("sparse_mask", 4'b1010, 2, 0, 12);
        run_segment("single_out", 4'b0100, 1, 0, 6);
        run_segment("div0_corner", 4'b0001, 0, 2, 9);

        // Clearing MASK during the index-2 dwell lets it finish, then drops to idle.
        bus.RUN  = 1'b0;
        bus.MASK = 4'b1111;
        bus.DIV  = DW'(3);
        bus.GAP  = GW'(0);
        tick();
        bus.RUN = 1'b1;
        for (int t = 0; t < 7; t++) begin
            tick();
            chk($sformatf("mask0_pre_t%0d", t), observed(), model(t, 4'b1111, 3, 0));
        end
        bus.MASK = 4'b0000;
        for (int t = 7; t < 11; t++) begin
            tick();
            chk($sformatf("mask0_t%0d", t), observed(), (t < 9) ? 5'b11000 : 5'b00000);
        end

        // Reset asserted mid-dwell overrides RUN.
        run_segment("pre_reset", 4'b0110, 4, 1, 2);
        rst = 1'b1;
        tick();
        chk("reset_mid_dwell", observed(), 5'b00000);
        rst = 1'b0;

        for (int s = 0; s < 12; s++) begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            run_segment($sformatf("rand%0d_m%b", s, m), m,
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
